video_ts_sched: RTL

VIDEO_TS_SCHED -- requirements
Module: video_ts_sched

---
 rtl/video_ts_sched_pkg.sv | 31 +++
 rtl/video_ts_layer_next.sv | 25 ++
 rtl/video_ts_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/video_ts_sched_pkg.sv
// Shared types for the video task scheduler: FSM states, the renderer task
// layout and the layer-to-source mapping.
package video_ts_sched_pkg;

    localparam int         NUM_LAYERS = 5;
    localparam logic [2:0] LAYER_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAYER = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // MSB-to-LSB order matches the 40-bit task buses of both sources
    typedef struct packed {
        logic [3:0] pal;
        logic [7:0] page;
        logic [8:0] line;
        logic [5:0] addr;
        logic       flip;
        logic [2:0] x_size;
        logic [8:0] x_coord;
    } ts_task_t;

    // Odd layers are fed by the tile source, even layers by the sprite source
    function automatic logic is_tile_layer(input logic [2:0] idx);
        return idx[0];
    endfunction

endpackage

// File: rtl/video_ts_layer_next.sv
// Finds the next enabled layer at or above (incl_cur=1) or strictly above
// (incl_cur=0) the given index.
module video_ts_layer_next
    import video_ts_sched_pkg::*;
(
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [2:0]            cur_idx,
    input  logic                  incl_cur,
    output logic [2:0]            next_idx,
    output logic                  none_left
);

    // Scan downwards so the lowest qualifying index is the one left standing
    always_comb begin
        next_idx  = LAYER_NONE;
        none_left = 1'b1;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && ((incl_cur && (3'(i) >= cur_idx)) || (3'(i) > cur_idx))) begin
                next_idx  = 3'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_ts_sched.sv
// Per-line layer scheduler: walks the enabled layers in order, hands sprite or
// tile tasks to the renderer, then waits for the renderer to drain.
module video_ts_sched
    import video_ts_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [4:0]  layer_en,
    input  logic        spr_valid,
    input  logic        spr_last,
    input  logic        spr_nop,
    input  logic [39:0] spr_task,
    output logic        spr_ready,
    input  logic        tile_valid,
    input  logic        tile_last,
    input  logic        tile_nop,
    input  logic [39:0] tile_task,
    output logic        tile_ready,
    input  logic        mem_rdy,
    output logic        tsr_go,
    output logic [8:0]  x_coord,
    output logic [2:0]  x_size,
    output logic        flip,
    output logic [5:0]  addr,
    output logic [8:0]  line,
    output logic [7:0]  page,
    output logic [3:0]  pal,
    output logic [2:0]  layer,
    output logic        line_done
);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       line_done_q, line_done_d;

    logic       in_layer, tile_sel;
    logic       g_valid, g_last, g_nop, handshake;
    ts_task_t   g_task, out_task;
    logic [2:0] first_idx, next_idx;
    logic       first_none, next_none;

    video_ts_layer_next u_first (
        .layer_en  (layer_en),
        .cur_idx   (3'd0),
        .incl_cur  (1'b1),
        .next_idx  (first_idx),
        .none_left (first_none)
    );

    video_ts_layer_next u_next (
        .layer_en  (layer_en),
        .cur_idx   (idx_q),
        .incl_cur  (1'b0),
        .next_idx  (next_idx),
        .none_left (next_none)
    );

    // A line_start in the same clk wins: the offered task is left unconsumed
    always_comb begin
        in_layer  = (state_q == ST_LAYER);
        tile_sel  = is_tile_layer(idx_q);
        g_valid   = in_layer && (tile_sel ? tile_valid : spr_valid);
        g_last    = tile_sel ? tile_last : spr_last;
        g_nop     = tile_sel ? tile_nop : spr_nop;
        g_task    = tile_sel ? ts_task_t'(tile_task) : ts_task_t'(spr_task);
        tsr_go    = g_valid && !g_nop && mem_rdy && !line_start;
        handshake = tsr_go || (g_valid && g_nop && !line_start);
        out_task  = in_layer ? g_task : '0;
    end

    assign spr_ready  = handshake && !tile_sel;
    assign tile_ready = handshake && tile_sel;
    assign x_coord    = out_task.x_coord;
    assign x_size     = out_task.x_size;
    assign flip       = out_task.flip;
    assign addr       = out_task.addr;
    assign line       = out_task.line;
    assign page       = out_task.page;
    assign pal        = out_task.pal;
    assign layer      = in_layer ? idx_q : LAYER_NONE;
    assign line_done  = line_done_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        line_done_d = 1'b0;
        if (line_start) begin
            if (first_none) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_LAYER;
                idx_d   = first_idx;
            end
        end else begin
            unique case (state_q)
                ST_LAYER: begin
                    if (handshake && g_last) begin
                        if (next_none) begin
                            state_d = ST_DRAIN;
                        end else begin
                            idx_d = next_idx;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_rdy) begin
                        state_d     = ST_DONE;
                        line_done_d = 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            line_done_q <= line_done_d;
        end
    end

endmodule
